// File: rtl/wallace_mac_16.sv
// Pipelined 16x16 unsigned multiply-accumulate built around a Wallace-tree multiplier.
// Optional macro WALLACE_MAC_SATURATE_EN clamps the accumulator on carry-out instead of wrapping.

module wallace_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] mul
);

  // Full-adder reduction of three rows into a sum row and a left-shifted carry row.
  function automatic logic [63:0] csa(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
    logic [31:0] s;
    logic [31:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {s, c};
  endfunction

  logic [31:0] l0 [16];
  logic [31:0] l1 [11];
  logic [31:0] l2 [8];
  logic [31:0] l3 [6];
  logic [31:0] l4 [4];
  logic [31:0] l5 [3];
  logic [31:0] l6 [2];

  // Row counts per level: 16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2, then one carry-propagate add.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      l0[i] = b[i] ? ({16'h0000, a} << i) : 32'h0;
    end
    for (int i = 0; i < 5; i++) begin
      {l1[2*i], l1[2*i+1]} = csa(l0[3*i], l0[3*i+1], l0[3*i+2]);
    end
    l1[10] = l0[15];
    for (int i = 0; i < 3; i++) begin
      {l2[2*i], l2[2*i+1]} = csa(l1[3*i], l1[3*i+1], l1[3*i+2]);
    end
    l2[6] = l1[9];
    l2[7] = l1[10];
    for (int i = 0; i < 2; i++) begin
      {l3[2*i], l3[2*i+1]} = csa(l2[3*i], l2[3*i+1], l2[3*i+2]);
    end
    l3[4] = l2[6];
    l3[5] = l2[7];
    for (int i = 0; i < 2; i++) begin
      {l4[2*i], l4[2*i+1]} = csa(l3[3*i], l3[3*i+1], l3[3*i+2]);
    end
    {l5[0], l5[1]} = csa(l4[0], l4[1], l4[2]);
    l5[2] = l4[3];
    {l6[0], l6[1]} = csa(l5[0], l5[1], l5[2]);
    mul = l6[0] + l6[1];
  end

endmodule

module wallace_mac_16 #(
  parameter int unsigned ACC_W = 40,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  input  logic             in_last,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  logic [15:0]      a1_q, b1_q;
  logic             last1_q, v1_q;
  logic [31:0]      mul;
  logic [31:0]      prod2_q;
  logic             last2_q, v2_q;
  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_upd;
  logic [CNT_W-1:0] cnt_inc;

  wallace_16bit u_mul (
    .a   (a1_q),
    .b   (b1_q),
    .mul (mul)
  );

  always_comb begin
    sum     = {1'b0, acc_q} + {{(ACC_W - 31){1'b0}}, prod2_q};
    carry   = sum[ACC_W];
`ifdef WALLACE_MAC_SATURATE_EN
    // Once clamped, every further non-zero term carries again, so the clamp is self-holding.
    acc_upd = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    acc_upd = sum[ACC_W-1:0];
`endif
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q      <= '0;
      b1_q      <= '0;
      last1_q   <= 1'b0;
      v1_q      <= 1'b0;
      prod2_q   <= '0;
      last2_q   <= 1'b0;
      v2_q      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      // Result registers deliberately keep the last completed dot product.
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q    <= in_a;
        b1_q    <= in_b;
        last1_q <= in_last;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        prod2_q <= mul;
        last2_q <= last1_q;
      end
      out_valid <= v2_q & last2_q;
      if (v2_q) begin
        if (last2_q) begin
          out_acc   <= acc_upd;
          out_count <= cnt_inc;
          out_ovf   <= ovf_q | carry;
          acc_q     <= '0;
          cnt_q     <= '0;
          ovf_q     <= 1'b0;
        end else begin
          acc_q <= acc_upd;
          cnt_q <= cnt_inc;
          ovf_q <= ovf_q | carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_wallace_mac_16.sv
// Scoreboard bench for wallace_mac_16: a default 40-bit instance and a 32-bit instance
// for the accumulator-overflow cases.

module tb_wallace_mac_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_s [2];
  logic        iv_s  [2];
  logic [15:0] a_s   [2];
  logic [15:0] b_s   [2];
  logic        l_s   [2];

  logic        ov0, ovf0, ov1, ovf1;
  logic [39:0] acc0;
  logic [31:0] acc1;
  logic [7:0]  cnt0, cnt1;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  typedef struct packed {
    logic [63:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
    int          when;
  } exp_t;

  exp_t q0 [$];
  exp_t q1 [$];
  exp_t e0, e1;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  wallace_mac_16 #(.ACC_W(40), .CNT_W(8)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s[0]),
    .in_valid  (iv_s[0]),
    .in_a      (a_s[0]),
    .in_b      (b_s[0]),
    .in_last   (l_s[0]),
    .out_valid (ov0),
    .out_acc   (acc0),
    .out_count (cnt0),
    .out_ovf   (ovf0)
  );

  wallace_mac_16 #(.ACC_W(32), .CNT_W(8)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s[1]),
    .in_valid  (iv_s[1]),
    .in_a      (a_s[1]),
    .in_b      (b_s[1]),
    .in_last   (l_s[1]),
    .out_valid (ov1),
    .out_acc   (acc1),
    .out_count (cnt1),
    .out_ovf   (ovf1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per out_valid pulse, independent of the stimulus thread.
  always @(negedge clk) begin
    if (ov0 !== 1'b0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse0: got out_valid=%b at edge %0d, expected no pulse",
                 ov0, edge_n);
      end else begin
        e0 = q0.pop_front();
        check("acc0", 64'(acc0), e0.acc);
        check("count0", 64'(cnt0), 64'(e0.cnt));
        check("ovf0", 64'(ovf0), 64'(e0.ovf));
        check("latency0", 64'(edge_n), 64'(e0.when));
      end
    end
    if (ov1 !== 1'b0) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse1: got out_valid=%b at edge %0d, expected no pulse",
                 ov1, edge_n);
      end else begin
        e1 = q1.pop_front();
        check("acc1", 64'(acc1), e1.acc);
        check("count1", 64'(cnt1), 64'(e1.cnt));
        check("ovf1", 64'(ovf1), 64'(e1.ovf));
        check("latency1", 64'(edge_n), 64'(e1.when));
      end
    end
  end

  // Called just after a rising edge; the sample is captured on the next edge.
  task automatic send(input int d, input logic [15:0] a, input logic [15:0] b, input logic last,
                      input bit exp_res, input logic [63:0] eacc, input logic [7:0] ecnt,
                      input logic eovf);
    exp_t e;
    iv_s[d] = 1'b1;
    a_s[d]  = a;
    b_s[d]  = b;
    l_s[d]  = last;
    if (exp_res) begin
      e.acc  = eacc;
      e.cnt  = ecnt;
      e.ovf  = eovf;
      e.when = edge_n + 3;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    @(posedge clk);
    #1;
    iv_s[d] = 1'b0;
    a_s[d]  = '0;
    b_s[d]  = '0;
    l_s[d]  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] ovf_case_acc;
`ifdef WALLACE_MAC_SATURATE_EN
    ovf_case_acc = 64'hFFFF_FFFF;
`else
    ovf_case_acc = 64'hFFFC_0002;
`endif
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      clr_s[i] = 1'b0;
      iv_s[i]  = 1'b0;
      a_s[i]   = '0;
      b_s[i]   = '0;
      l_s[i]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_valid0", 64'(ov0), 64'd0);
    check("rst_acc0", 64'(acc0), 64'd0);
    check("rst_count0", 64'(cnt0), 64'd0);
    check("rst_ovf0", 64'(ovf0), 64'd0);
    check("rst_valid1", 64'(ov1), 64'd0);
    check("rst_acc1", 64'(acc1), 64'd0);

    // Single-term dot product.
    send(0, 16'h2003, 16'h0004, 1'b1, 1'b1, 64'h800C, 8'd1, 1'b0);
    idle(4);

    // Three back-to-back terms: 15 + 14 + 0xFFFE0001.
    send(0, 16'd3, 16'd5, 1'b0, 1'b0, '0, '0, 1'b0);
    send(0, 16'd7, 16'd2, 1'b0, 1'b0, '0, '0, 1'b0);
    send(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 64'hFFFE_001E, 8'd3, 1'b0);
    idle(4);

    // Same terms with bubbles between them.
    send(0, 16'd3, 16'd5, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(2);
    send(0, 16'd7, 16'd2, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(2);
    send(0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 64'hFFFE_001E, 8'd3, 1'b0);
    idle(4);

    // Consecutive last samples give consecutive pulses.
    send(0, 16'd2, 16'd3, 1'b1, 1'b1, 64'd6, 8'd1, 1'b0);
    send(0, 16'd4, 16'd5, 1'b1, 1'b1, 64'd20, 8'd1, 1'b0);
    idle(4);

    // 32-bit accumulator overflow.
    send(1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, '0, '0, 1'b0);
    send(1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, ovf_case_acc, 8'd2, 1'b1);
    idle(4);

    // clr with a simultaneous sample flushes everything in flight.
    send(0, 16'd1, 16'd1, 1'b0, 1'b0, '0, '0, 1'b0);
    send(0, 16'd2, 16'd2, 1'b0, 1'b0, '0, '0, 1'b0);
    clr_s[0] = 1'b1;
    send(0, 16'd3, 16'd3, 1'b1, 1'b0, '0, '0, 1'b0);
    clr_s[0] = 1'b0;
    check("clr_valid0", 64'(ov0), 64'd0);
    check("clr_hold_acc0", 64'(acc0), 64'd20);
    idle(4);
    send(0, 16'd6, 16'd7, 1'b1, 1'b1, 64'd42, 8'd1, 1'b0);
    idle(4);

    // Asynchronous reset mid-stream.
    send(0, 16'd9, 16'd9, 1'b0, 1'b0, '0, '0, 1'b0);
    send(0, 16'd8, 16'd8, 1'b1, 1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    #2;
    check("midrst_acc0", 64'(acc0), 64'd0);
    check("midrst_count0", 64'(cnt0), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    send(0, 16'd6, 16'd7, 1'b1, 1'b1, 64'd42, 8'd1, 1'b0);
    idle(4);

    for (int i = 0; i < 10 && (q0.size() != 0 || q1.size() != 0); i++) idle(1);
    check("drain0", 64'(q0.size()), 64'd0);
    check("drain1", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
